inst_seq_ctrl: RTL and testbench

Parametrised instruction and cycle sequencer for the 6502 core. It sits between the data bus and the decoder and owns five pieces of state: the opcode register, the timing-cycle counter, the predecode register, the interrupt-pending logic and the ready stall. It extends the basic controller in four ways: NMI edge detection, masked IRQ, power-on reset sequencing through an injected opcode, and a RDY stall. It also reports which interrupt source caused each injection, so the microcode can select the vector.

---
 rtl/inst_ctrl_pkg.sv | 13 +
 rtl/pd_reg.sv | 17 +
 rtl/inst_seq_ctrl.sv | 118 +++++++++++
 tb/tb_inst_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ctrl_pkg.sv
// Shared encodings for the 6502 instruction/cycle sequencer.
package inst_ctrl_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_IRQ  = 2'd1,
    INT_NMI  = 2'd2,
    INT_RES  = 2'd3
  } int_src_e;

  localparam int unsigned CYC_FETCH = 1;

endpackage

// File: rtl/pd_reg.sv
// Predecode register: captures the data bus on every enabled edge.
module pd_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/inst_seq_ctrl.sv
// Instruction and timing-cycle sequencer for the 6502 core: opcode fetch,
// predecode, NMI/IRQ/reset injection and RDY stall.
module inst_seq_ctrl
  import inst_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       CYC_W     = 3,
  parameter logic [DATA_W-1:0] INJECT_OP = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              rdy,
  input  logic              iCyc,
  input  logic              sCyc,
  input  logic              rCyc,
  input  logic              irq,
  input  logic              nmi,
  input  logic              iFlag,
  output logic              sync,
  output logic [DATA_W-1:0] ir,
  output logic [CYC_W-1:0]  cycle,
  output logic [DATA_W-1:0] pdOut,
  output logic [1:0]        intSrc,
  output logic              injected
);

  logic [CYC_W-1:0]  cycle_q;
  logic [CYC_W-1:0]  nxtcycle;
  logic              fetch;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] nxt_ir;
  int_src_e          src_q;
  int_src_e          nxt_src;
  logic              inj_q;
  logic              nxt_inj;
  logic              nmi_d;
  logic              nmi_pend;
  logic              res_pend;
  logic              take_nmi;

  always_comb begin
    nxtcycle = cycle_q;
    if (rCyc)      nxtcycle = '0;
    else if (iCyc) nxtcycle = cycle_q + CYC_W'(1);
    else if (sCyc) nxtcycle = cycle_q + CYC_W'(2);
  end

  assign fetch = rdy & (nxtcycle == CYC_W'(CYC_FETCH));

  // Reset outranks NMI, NMI outranks unmasked IRQ; irq is sampled live.
  always_comb begin
    nxt_ir   = dataIn;
    nxt_src  = INT_NONE;
    nxt_inj  = 1'b0;
    take_nmi = 1'b0;
    if (res_pend) begin
      nxt_ir  = INJECT_OP;
      nxt_src = INT_RES;
      nxt_inj = 1'b1;
    end else if (nmi_pend) begin
      nxt_ir   = INJECT_OP;
      nxt_src  = INT_NMI;
      nxt_inj  = 1'b1;
      take_nmi = fetch;
    end else if (irq & ~iFlag) begin
      nxt_ir  = INJECT_OP;
      nxt_src = INT_IRQ;
      nxt_inj = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      ir_q     <= '0;
      src_q    <= INT_NONE;
      inj_q    <= 1'b0;
      res_pend <= 1'b1;
    end else if (rdy) begin
      cycle_q <= nxtcycle;
      if (fetch) begin
        ir_q     <= nxt_ir;
        src_q    <= nxt_src;
        inj_q    <= nxt_inj;
        res_pend <= 1'b0;
      end
    end
  end

  // Edge detector runs through stalls; a new edge beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_d    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_d    <= nmi;
      nmi_pend <= (nmi & ~nmi_d) | (nmi_pend & ~take_nmi);
    end
  end

  pd_reg #(
    .DATA_W(DATA_W)
  ) u_pd_reg (
    .clk(clk),
    .rst(rst),
    .en (rdy),
    .d  (dataIn),
    .q  (pdOut)
  );

  assign sync     = fetch;
  assign ir       = ir_q;
  assign cycle    = cycle_q;
  assign intSrc   = src_q;
  assign injected = inj_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed self-checking bench for inst_seq_ctrl.
module tb_inst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dataIn = '0;
  logic       rdy = 1'b1;
  logic       iCyc = 1'b0, sCyc = 1'b0, rCyc = 1'b0;
  logic       irq = 1'b0, nmi = 1'b0, iFlag = 1'b1;
  logic       sync;
  logic [7:0] ir;
  logic [2:0] cycle;
  logic [7:0] pdOut;
  logic [1:0] intSrc;
  logic       injected;

  int tests = 0;
  int fails = 0;

  inst_seq_ctrl #(
    .DATA_W   (8),
    .CYC_W    (3),
    .INJECT_OP(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .rdy(rdy),
    .iCyc(iCyc), .sCyc(sCyc), .rCyc(rCyc),
    .irq(irq), .nmi(nmi), .iFlag(iFlag),
    .sync(sync), .ir(ir), .cycle(cycle), .pdOut(pdOut),
    .intSrc(intSrc), .injected(injected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cyc(input logic i, input logic s, input logic r);
    iCyc = i; sCyc = s; rCyc = r;
  endtask

  // Two-edge instruction: return to cycle 0, then fetch with data d.
  task automatic instr(input logic [7:0] d);
    set_cyc(0, 0, 1);
    step();
    set_cyc(1, 0, 0);
    dataIn = d;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests++; if (cycle !== 3'd0)   begin fails++; $display("FAIL rst_cycle: got %0d expected 0", cycle); end
    tests++; if (ir !== 8'h00)     begin fails++; $display("FAIL rst_ir: got %h expected 00", ir); end
    tests++; if (pdOut !== 8'h00)  begin fails++; $display("FAIL rst_pd: got %h expected 00", pdOut); end
    tests++; if (intSrc !== 2'd0)  begin fails++; $display("FAIL rst_src: got %0d expected 0", intSrc); end
    tests++; if (injected !== 1'b0) begin fails++; $display("FAIL rst_inj: got %b expected 0", injected); end
    rst = 1'b0;
    set_cyc(1, 0, 0);
    dataIn = 8'h4C;
    repeat (5) step();
    tests++; if (cycle !== 3'd5) begin fails++; $display("FAIL pre_rst_cycle: got %0d expected 5", cycle); end
    // asynchronous reset in mid-cycle
    #2 rst = 1'b1;
    #1;
    tests++; if (cycle !== 3'd0) begin fails++; $display("FAIL async_rst_cycle: got %0d expected 0", cycle); end
    tests++; if (ir !== 8'h00)   begin fails++; $display("FAIL async_rst_ir: got %h expected 00", ir); end
    #1 rst = 1'b0;
    dataIn = 8'hA9;
    #1;
    tests++; if (sync !== 1'b1) begin fails++; $display("FAIL rst_sync: got %b expected 1", sync); end
    step();
    tests++; if (ir !== 8'h00 || injected !== 1'b1 || intSrc !== 2'd3)
      begin fails++; $display("FAIL res_inject: got ir=%h inj=%b src=%0d expected ir=00 inj=1 src=3", ir, injected, intSrc); end
    tests++; if (cycle !== 3'd1) begin fails++; $display("FAIL res_cycle: got %0d expected 1", cycle); end
    instr(8'hA9);
    tests++; if (ir !== 8'hA9 || injected !== 1'b0 || intSrc !== 2'd0)
      begin fails++; $display("FAIL post_res_fetch: got ir=%h inj=%b src=%0d expected ir=a9 inj=0 src=0", ir, injected, intSrc); end
  endtask

  task automatic test_cycle_arith();
    set_cyc(0, 0, 1); step();
    set_cyc(0, 1, 0); repeat (3) step();
    tests++; if (cycle !== 3'd6) begin fails++; $display("FAIL cyc_6: got %0d expected 6", cycle); end
    set_cyc(1, 0, 0); step();
    tests++; if (cycle !== 3'd7) begin fails++; $display("FAIL cyc_7: got %0d expected 7", cycle); end
    step();
    tests++; if (cycle !== 3'd0) begin fails++; $display("FAIL cyc_wrap: got %0d expected 0", cycle); end
    set_cyc(0, 1, 0); repeat (3) step();
    set_cyc(1, 0, 0); step();
    tests++; if (cycle !== 3'd7) begin fails++; $display("FAIL cyc_7b: got %0d expected 7", cycle); end
    set_cyc(0, 1, 0);
    dataIn = 8'h3E;
    #1;
    tests++; if (sync !== 1'b1) begin fails++; $display("FAIL skip_sync: got %b expected 1", sync); end
    step();
    tests++; if (cycle !== 3'd1 || ir !== 8'h3E)
      begin fails++; $display("FAIL skip_wrap: got cyc=%0d ir=%h expected cyc=1 ir=3e", cycle, ir); end
    set_cyc(1, 0, 1);
    #1;
    tests++; if (sync !== 1'b0) begin fails++; $display("FAIL ir_sync: got %b expected 0", sync); end
    step();
    tests++; if (cycle !== 3'd0) begin fails++; $display("FAIL ir_prio: got %0d expected 0", cycle); end
    set_cyc(1, 1, 0); step();
    tests++; if (cycle !== 3'd1) begin fails++; $display("FAIL is_prio: got %0d expected 1", cycle); end
  endtask

  task automatic test_nmi();
    int cnt;
    cnt = 0;
    nmi = 1'b1; set_cyc(0, 0, 1); step();
    nmi = 1'b0; set_cyc(1, 0, 0); dataIn = 8'hEA; step();
    if (injected && intSrc == 2'd2) cnt++;
    repeat (2) begin
      instr(8'hEA);
      if (injected && intSrc == 2'd2) cnt++;
    end
    tests++; if (cnt !== 1) begin fails++; $display("FAIL nmi_pulse_count: got %0d expected 1", cnt); end
    cnt = 0;
    nmi = 1'b1;
    repeat (5) begin
      instr(8'hEA);
      if (injected && intSrc == 2'd2) cnt++;
    end
    tests++; if (cnt !== 1) begin fails++; $display("FAIL nmi_hold_count: got %0d expected 1", cnt); end
    // new rising edge on the very edge that takes the pending NMI
    nmi = 1'b0; set_cyc(0, 0, 1); step();
    nmi = 1'b1; step();
    nmi = 1'b0; step();
    nmi = 1'b1; set_cyc(1, 0, 0); step();
    tests++; if (ir !== 8'h00 || injected !== 1'b1 || intSrc !== 2'd2)
      begin fails++; $display("FAIL nmi_coinc_first: got ir=%h inj=%b src=%0d expected ir=00 inj=1 src=2", ir, injected, intSrc); end
    instr(8'hEA);
    tests++; if (injected !== 1'b1 || intSrc !== 2'd2)
      begin fails++; $display("FAIL nmi_coinc_second: got inj=%b src=%0d expected inj=1 src=2", injected, intSrc); end
    instr(8'hEA);
    tests++; if (ir !== 8'hEA || injected !== 1'b0)
      begin fails++; $display("FAIL nmi_after: got ir=%h inj=%b expected ir=ea inj=0", ir, injected); end
    nmi = 1'b0;
    step();
  endtask

  task automatic test_irq();
    irq = 1'b1; iFlag = 1'b1;
    instr(8'h55);
    tests++; if (ir !== 8'h55 || injected !== 1'b0)
      begin fails++; $display("FAIL irq_masked: got ir=%h inj=%b expected ir=55 inj=0", ir, injected); end
    iFlag = 1'b0;
    instr(8'h56);
    tests++; if (ir !== 8'h00 || injected !== 1'b1 || intSrc !== 2'd1)
      begin fails++; $display("FAIL irq_take: got ir=%h inj=%b src=%0d expected ir=00 inj=1 src=1", ir, injected, intSrc); end
    irq = 1'b1; set_cyc(0, 0, 1); step();
    irq = 1'b0; set_cyc(1, 0, 0); dataIn = 8'h57; step();
    tests++; if (ir !== 8'h57 || injected !== 1'b0)
      begin fails++; $display("FAIL irq_lost: got ir=%h inj=%b expected ir=57 inj=0", ir, injected); end
    irq = 1'b1; nmi = 1'b1;
    instr(8'h58);
    tests++; if (intSrc !== 2'd2 || injected !== 1'b1)
      begin fails++; $display("FAIL nmi_over_irq: got src=%0d inj=%b expected src=2 inj=1", intSrc, injected); end
    instr(8'h59);
    tests++; if (intSrc !== 2'd1 || injected !== 1'b1)
      begin fails++; $display("FAIL irq_after_nmi: got src=%0d inj=%b expected src=1 inj=1", intSrc, injected); end
    irq = 1'b0; nmi = 1'b0; iFlag = 1'b1;
    step();
  endtask

  task automatic test_rdy();
    instr(8'h77);
    tests++; if (ir !== 8'h77 || cycle !== 3'd1 || pdOut !== 8'h77)
      begin fails++; $display("FAIL rdy_pre: got ir=%h cyc=%0d pd=%h expected ir=77 cyc=1 pd=77", ir, cycle, pdOut); end
    rdy = 1'b0; dataIn = 8'h88; set_cyc(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) nmi = 1'b1;
      #1;
      tests++; if (sync !== 1'b0) begin fails++; $display("FAIL stall_sync[%0d]: got %b expected 0", k, sync); end
      step();
      tests++; if (cycle !== 3'd1 || ir !== 8'h77 || pdOut !== 8'h77)
        begin fails++; $display("FAIL stall_hold[%0d]: got cyc=%0d ir=%h pd=%h expected cyc=1 ir=77 pd=77", k, cycle, ir, pdOut); end
    end
    nmi = 1'b0;
    rdy = 1'b1;
    set_cyc(0, 0, 1); step();
    tests++; if (pdOut !== 8'h88) begin fails++; $display("FAIL rdy_resume_pd: got %h expected 88", pdOut); end
    set_cyc(1, 0, 0); step();
    tests++; if (ir !== 8'h00 || injected !== 1'b1 || intSrc !== 2'd2)
      begin fails++; $display("FAIL stall_nmi: got ir=%h inj=%b src=%0d expected ir=00 inj=1 src=2", ir, injected, intSrc); end
  endtask

  task automatic test_predecode();
    logic [7:0] vals [3];
    logic [7:0] prev;
    vals[0] = 8'h10; vals[1] = 8'h11; vals[2] = 8'h12;
    set_cyc(0, 0, 1);
    dataIn = 8'h0F; step();
    prev = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      dataIn = vals[k];
      #1;
      tests++; if (pdOut !== prev) begin fails++; $display("FAIL pd_before[%0d]: got %h expected %h", k, pdOut, prev); end
      step();
      tests++; if (pdOut !== vals[k]) begin fails++; $display("FAIL pd_after[%0d]: got %h expected %h", k, pdOut, vals[k]); end
      prev = vals[k];
    end
  endtask

  initial begin
    test_reset();
    test_cycle_arith();
    test_nmi();
    test_irq();
    test_rdy();
    test_predecode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
